// File: rtl/cnn_stream_pkg.sv
// Shared types and default sizes for the CNN streaming datapath blocks.
package cnn_stream_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int PARA       = 4;
  localparam int FRAME_LEN  = 16;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Drain sequencer of spn_feeder: one lead cycle, then the vector burst.
  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    BURST
  } feed_state_t;

endpackage

// File: rtl/frame_bank.sv
// One frame worth of word storage: written one word at a time, read one
// PARA-word row (vector) at a time. Contents are not reset.
module frame_bank #(
  parameter int  DATA_WIDTH = cnn_stream_pkg::DATA_WIDTH,
  parameter int  PARA       = cnn_stream_pkg::PARA,
  parameter int  FRAME_LEN  = cnn_stream_pkg::FRAME_LEN,
  localparam int IDX_W      = $clog2(FRAME_LEN),
  localparam int ROW_W      = $clog2(FRAME_LEN / PARA)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ROW_W-1:0]      row_i,
  output logic [DATA_WIDTH-1:0] row_o [PARA]
);

  logic [DATA_WIDTH-1:0] mem_q [FRAME_LEN];

  // Serial write port: one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= data_i;
    end
  end

  // Row read port: lane i of row r is word r*PARA+i.
  always_comb begin
    for (int i = 0; i < PARA; i++) begin
      row_o[i] = mem_q[IDX_W'(int'(row_i) * PARA + i)];
    end
  end

endmodule

// File: rtl/spn_feeder.sv
// Serial-to-parallel frame packer feeding the spn. Words fill one bank while
// the other, completed, bank is burst out as PARA-lane vectors with valid
// leading the data by one clock.
module spn_feeder #(
  parameter int DATA_WIDTH = cnn_stream_pkg::DATA_WIDTH,
  parameter int PARA       = cnn_stream_pkg::PARA,
  parameter int FRAME_LEN  = cnn_stream_pkg::FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] output_stream [PARA-1:0],
  output logic                  valid_out
);

  import cnn_stream_pkg::feed_state_t;
  import cnn_stream_pkg::IDLE;
  import cnn_stream_pkg::LEAD;
  import cnn_stream_pkg::BURST;

  localparam int N_VEC = FRAME_LEN / PARA;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int ROW_W = $clog2(N_VEC);

  // Fill side
  logic [IDX_W-1:0] wrIdx_q;
  logic             bankSel_q;
  logic             drainBank_q;
  logic             drainReq_q;
  logic             frameDone;
  logic             reqTake;

  // Drain side
  feed_state_t           state_q, state_d;
  logic [ROW_W-1:0]      rdVec_q, rdVec_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] stream_q [PARA-1:0];
  logic [DATA_WIDTH-1:0] stream_d [PARA-1:0];
  logic [DATA_WIDTH-1:0] row0 [PARA];
  logic [DATA_WIDTH-1:0] row1 [PARA];

  assign frameDone = valid_in && (wrIdx_q == IDX_W'(FRAME_LEN - 1));

  frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARA       (PARA),
    .FRAME_LEN  (FRAME_LEN)
  ) u_bank0 (
    .clk    (clk),
    .we_i   (valid_in && !bankSel_q),
    .idx_i  (wrIdx_q),
    .data_i (data_in),
    .row_i  (rdVec_q),
    .row_o  (row0)
  );

  frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARA       (PARA),
    .FRAME_LEN  (FRAME_LEN)
  ) u_bank1 (
    .clk    (clk),
    .we_i   (valid_in && bankSel_q),
    .idx_i  (wrIdx_q),
    .data_i (data_in),
    .row_i  (rdVec_q),
    .row_o  (row1)
  );

  // Write pointer, bank ping-pong and the pending drain request; a completed
  // frame hands its bank to the drain side and stays requested until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrIdx_q     <= '0;
      bankSel_q   <= 1'b0;
      drainBank_q <= 1'b0;
      drainReq_q  <= 1'b0;
    end else begin
      if (valid_in) begin
        if (frameDone) begin
          wrIdx_q     <= '0;
          bankSel_q   <= !bankSel_q;
          drainBank_q <= bankSel_q;
        end else begin
          wrIdx_q <= wrIdx_q + 1'b1;
        end
      end
      if (frameDone) begin
        drainReq_q <= 1'b1;
      end else if (reqTake) begin
        drainReq_q <= 1'b0;
      end
    end
  end

  // Drain sequencer next state and next output values; the row for rdVec_q is
  // loaded into the output registers while in LEAD or BURST.
  always_comb begin
    state_d = state_q;
    rdVec_d = rdVec_q;
    valid_d = 1'b0;
    reqTake = 1'b0;
    for (int i = 0; i < PARA; i++) begin
      stream_d[i] = '0;
    end
    case (state_q)
      IDLE: begin
        if (drainReq_q) begin
          reqTake = 1'b1;
          state_d = LEAD;
          rdVec_d = '0;
          valid_d = 1'b1;
        end
      end
      LEAD, BURST: begin
        for (int i = 0; i < PARA; i++) begin
          stream_d[i] = drainBank_q ? row1[i] : row0[i];
        end
        valid_d = (rdVec_q != ROW_W'(N_VEC - 1));
        rdVec_d = rdVec_q + 1'b1;
        state_d = (rdVec_q == ROW_W'(N_VEC - 1)) ? IDLE : BURST;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drain state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdVec_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < PARA; i++) begin
        stream_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rdVec_q <= rdVec_d;
      valid_q <= valid_d;
      for (int i = 0; i < PARA; i++) begin
        stream_q[i] <= stream_d[i];
      end
    end
  end

  assign valid_out     = valid_q;
  assign output_stream = stream_q;

endmodule

// File: tb/tb_spn_feeder.sv
// Self-checking bench for spn_feeder: a frame model schedules the expected
// valid cycles and vectors, and every clock the DUT outputs are compared.
module tb_spn_feeder;

  localparam int DW        = 32;
  localparam int PARA      = 4;
  localparam int FRAME_LEN = 16;
  localparam int N_VEC     = FRAME_LEN / PARA;

  logic          clk = 1'b0;
  logic          rst;
  logic          validIn;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] outputStream [PARA-1:0];
  logic          validOut;

  always #5 clk = ~clk;

  spn_feeder #(
    .DATA_WIDTH (DW),
    .PARA       (PARA),
    .FRAME_LEN  (FRAME_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (dataIn),
    .valid_in      (validIn),
    .output_stream (outputStream),
    .valid_out     (validOut)
  );

  typedef struct {
    int                       cyc;
    logic [PARA-1:0][DW-1:0]  lanes;
  } vecExp_t;

  typedef struct {
    string         name;
    logic [DW-1:0] startVal;
    int            gapLen;
    int            frames;
    logic [DW-1:0] expFirstLane0;
    int            expValidCycles;
  } frameCase_t;

  vecExp_t       vecQ [$];
  int            validQ [$];
  logic [DW-1:0] frameBuf [FRAME_LEN];
  int            fillCount = 0;
  int            cyc = 0;
  int            compared = 0;
  int            mismatched = 0;

  // Observation trackers for the table-level checks.
  int            validSeen = 0;
  logic          prevValid = 1'b0;
  logic          captured = 1'b0;
  logic [DW-1:0] firstLane0 = '0;

  // Expected behaviour at the edge that just sampled (r, v, d).
  task automatic modelEdge(input logic r, input logic v, input logic [DW-1:0] d);
    vecExp_t e;
    if (r) begin
      fillCount = 0;
      vecQ.delete();
      validQ.delete();
    end else if (v) begin
      frameBuf[fillCount] = d;
      fillCount++;
      if (fillCount == FRAME_LEN) begin
        for (int k = 0; k < N_VEC; k++) begin
          validQ.push_back(cyc + 1 + k);
          e.cyc = cyc + 2 + k;
          for (int i = 0; i < PARA; i++) begin
            e.lanes[i] = frameBuf[k * PARA + i];
          end
          vecQ.push_back(e);
        end
        fillCount = 0;
      end
    end
  endtask

  task automatic checkOutput();
    logic                    expV;
    logic [PARA-1:0][DW-1:0] expLanes;
    logic [PARA-1:0][DW-1:0] actLanes;
    expV     = 1'b0;
    expLanes = '0;
    if (validQ.size() > 0 && validQ[0] == cyc) begin
      expV = 1'b1;
      void'(validQ.pop_front());
    end
    if (vecQ.size() > 0 && vecQ[0].cyc == cyc) begin
      expLanes = vecQ[0].lanes;
      void'(vecQ.pop_front());
    end
    for (int i = 0; i < PARA; i++) begin
      actLanes[i] = outputStream[i];
    end
    compared++;
    if (validOut !== expV) begin
      mismatched++;
      $display("[TB] FAIL valid_out cyc=%0d actual=%0b required=%0b", cyc, validOut, expV);
    end
    compared++;
    if (actLanes !== expLanes) begin
      mismatched++;
      $display("[TB] FAIL lanes cyc=%0d actual=%h required=%h", cyc, actLanes, expLanes);
    end
    if (validOut === 1'b1) validSeen++;
    if (!captured && prevValid) begin
      firstLane0 = outputStream[0];
      captured   = 1'b1;
    end
    prevValid = validOut;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d);
    rst     = r;
    validIn = v;
    dataIn  = d;
    @(posedge clk);
    cyc++;
    modelEdge(r, v, d);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom);
  endtask

  task automatic resetTrackers();
    validSeen = 0;
    prevValid = 1'b0;
    captured  = 1'b0;
  endtask

  task automatic checkCount(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  frameCase_t cases [4];

  initial begin
    cases[0] = '{"continuous", 32'd1, 0, 1, 32'd1, N_VEC};
    cases[1] = '{"gapped", 32'd1, 1, 1, 32'd1, N_VEC};
    cases[2] = '{"back_to_back", 32'd1, 0, 2, 32'd1, 2 * N_VEC};
    cases[3] = '{"high_bits", 32'hFFFF_FFF0, 2, 1, 32'hFFFF_FFF0, N_VEC};

    rst     = 1'b1;
    validIn = 1'b0;
    dataIn  = '0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom);
    idle(1);

    foreach (cases[c]) begin
      $display("[TB] case %s", cases[c].name);
      resetTrackers();
      for (int w = 0; w < cases[c].frames * FRAME_LEN; w++) begin
        applyStimulus(1'b0, 1'b1, cases[c].startVal + DW'(w));
        for (int g = 0; g < cases[c].gapLen; g++) applyStimulus(1'b0, 1'b0, $urandom);
      end
      idle(8);
      checkCount({cases[c].name, "_valid_cycles"}, validSeen, cases[c].expValidCycles);
      compared++;
      if (!captured || firstLane0 !== cases[c].expFirstLane0) begin
        mismatched++;
        $display("[TB] FAIL %s_first_lane0 actual=%h required=%h", cases[c].name, firstLane0,
                 cases[c].expFirstLane0);
      end
    end

    $display("[TB] reset mid-fill");
    resetTrackers();
    for (int w = 0; w < 10; w++) applyStimulus(1'b0, 1'b1, DW'(50 + w));
    applyStimulus(1'b1, 1'b1, 32'd999);
    for (int w = 0; w < FRAME_LEN; w++) applyStimulus(1'b0, 1'b1, DW'(100 + w));
    idle(8);
    checkCount("midfill_valid_cycles", validSeen, N_VEC);
    compared++;
    if (firstLane0 !== 32'd100) begin
      mismatched++;
      $display("[TB] FAIL midfill_first_lane0 actual=%0d required=100", firstLane0);
    end

    $display("[TB] reset during burst");
    for (int w = 0; w < FRAME_LEN; w++) applyStimulus(1'b0, 1'b1, DW'(200 + w));
    idle(3);
    applyStimulus(1'b1, 1'b0, $urandom);
    resetTrackers();
    idle(12);
    checkCount("post_burst_reset_valid_cycles", validSeen, 0);

    $display("[TB] partial frame held");
    resetTrackers();
    for (int w = 0; w < FRAME_LEN - 1; w++) applyStimulus(1'b0, 1'b1, DW'(300 + w));
    idle(100);
    checkCount("partial_valid_cycles", validSeen, 0);
    applyStimulus(1'b0, 1'b1, DW'(300 + FRAME_LEN - 1));
    idle(8);
    checkCount("completed_valid_cycles", validSeen, N_VEC);

    checkCount("pending_vectors", vecQ.size(), 0);
    checkCount("pending_valids", validQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
